// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF engine.
package puf_pkg;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned MAJ_PASSES  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CLEAR,
      ST_COUNT,
      ST_COMPARE,
      ST_DONE
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Synchronises one RO output, detects rising edges and counts them with saturation.
module puf_edge_counter
   import puf_pkg::*;
#(
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ro,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_rise;

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         o_cnt  <= '0;
      end else if (i_clr) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         o_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_ro};
         r_prev <= r_sync[SYNC_STAGES-1];
         if (i_en && w_rise && (o_cnt != CNT_MAX)) o_cnt <= o_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/puf_word.sv
// RO-PUF engine: one RESP_W-bit response per challenge by comparing RO edge counts.
// Define PUF_MAJORITY_EN to evaluate every bit as a 2-of-3 vote over three counting passes.
module puf_word
   import puf_pkg::*;
#(
   parameter int unsigned N_RO          = 16,
   parameter int unsigned RESP_W        = 8,
   parameter int unsigned CNT_W         = 12,
   parameter int unsigned WIN_CYCLES    = 256,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_start,
   input  logic [2*clog2(N_RO)-1:0]   i_chall,
   input  logic [N_RO-1:0]            i_ro_a,
   input  logic [N_RO-1:0]            i_ro_b,
   output logic                       o_ro_en,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [RESP_W-1:0]          o_resp,
   output logic [RESP_W-1:0]          o_tie
);

   localparam int unsigned SEL_W   = clog2(N_RO);
   localparam int unsigned BIT_W   = (RESP_W > 1) ? clog2(RESP_W) : 1;
   localparam int unsigned TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TMR_W   = clog2(TMR_MAX) + 1;

   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(RESP_W - 1);

   state_t              r_state;
   logic [SEL_W-1:0]    r_sel_a;
   logic [SEL_W-1:0]    r_sel_b;
   logic [BIT_W-1:0]    r_bit;
   logic [TMR_W-1:0]    r_tmr;
   logic [RESP_W-1:0]   r_sh_resp;
   logic [RESP_W-1:0]   r_sh_tie;

   logic [SEL_W-1:0]    w_idx_a;
   logic [SEL_W-1:0]    w_idx_b;
   logic                w_clr;
   logic                w_cnt_en;
   logic [CNT_W-1:0]    w_cnt_a;
   logic [CNT_W-1:0]    w_cnt_b;
   logic                w_gt;
   logic                w_eq;
   logic                w_bit_val;
   logic                w_bit_tie;
   logic                w_last_pass;
   logic [RESP_W-1:0]   w_sh_resp_nx;
   logic [RESP_W-1:0]   w_sh_tie_nx;

   // Per-bit RO pairs walk upward from the base selects, wrapping modulo N_RO.
   assign w_idx_a  = r_sel_a + SEL_W'(r_bit);
   assign w_idx_b  = r_sel_b + SEL_W'(r_bit);
   assign w_clr    = (r_state == ST_CLEAR);
   assign w_cnt_en = (r_state == ST_COUNT);
   assign w_gt     = (w_cnt_a > w_cnt_b);
   assign w_eq     = (w_cnt_a == w_cnt_b);

   puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ro  (i_ro_a[w_idx_a]),
      .i_clr (w_clr),
      .i_en  (w_cnt_en),
      .o_cnt (w_cnt_a)
   );

   puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ro  (i_ro_b[w_idx_b]),
      .i_clr (w_clr),
      .i_en  (w_cnt_en),
      .o_cnt (w_cnt_b)
   );

`ifdef PUF_MAJORITY_EN
   localparam logic [1:0] PASS_LAST = 2'(MAJ_PASSES - 1);

   logic [1:0] r_pass;
   logic [1:0] r_votes;
   logic       r_any_tie;

   // Tied passes vote 0 because w_gt is low on equality.
   assign w_last_pass = (r_pass == PASS_LAST);
   assign w_bit_val   = (r_votes == 2'd2) || ((r_votes == 2'd1) && w_gt);
   assign w_bit_tie   = r_any_tie | w_eq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pass    <= '0;
         r_votes   <= '0;
         r_any_tie <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_pass    <= '0;
         r_votes   <= '0;
         r_any_tie <= 1'b0;
      end else if (r_state == ST_COMPARE) begin
         if (w_last_pass) begin
            r_pass    <= '0;
            r_votes   <= '0;
            r_any_tie <= 1'b0;
         end else begin
            r_pass    <= r_pass + 1'b1;
            r_votes   <= r_votes + {1'b0, w_gt};
            r_any_tie <= r_any_tie | w_eq;
         end
      end
   end
`else
   assign w_last_pass = 1'b1;
   assign w_bit_val   = w_gt;
   assign w_bit_tie   = w_eq;
`endif

   always_comb begin
      w_sh_resp_nx        = r_sh_resp;
      w_sh_tie_nx         = r_sh_tie;
      w_sh_resp_nx[r_bit] = w_bit_val;
      w_sh_tie_nx[r_bit]  = w_bit_tie;
   end

   // Sequencer; the final bit is merged on the fly so resp/tie update with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sel_a   <= '0;
         r_sel_b   <= '0;
         r_bit     <= '0;
         r_tmr     <= '0;
         r_sh_resp <= '0;
         r_sh_tie  <= '0;
         o_ro_en   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_resp    <= '0;
         o_tie     <= '0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_sel_a <= i_chall[SEL_W-1:0];
                  r_sel_b <= i_chall[2*SEL_W-1:SEL_W];
                  r_bit   <= '0;
                  r_tmr   <= '0;
                  o_ro_en <= 1'b1;
                  o_busy  <= 1'b1;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_tmr == SETTLE_LAST) begin
                  r_tmr   <= '0;
                  r_state <= ST_CLEAR;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            ST_CLEAR: begin
               r_tmr   <= '0;
               r_state <= ST_COUNT;
            end
            ST_COUNT: begin
               if (r_tmr == WIN_LAST) r_state <= ST_COMPARE;
               else                   r_tmr   <= r_tmr + 1'b1;
            end
            ST_COMPARE: begin
               r_state <= ST_CLEAR;
               if (w_last_pass) begin
                  r_sh_resp <= w_sh_resp_nx;
                  r_sh_tie  <= w_sh_tie_nx;
                  if (r_bit == BIT_LAST) begin
                     o_resp  <= w_sh_resp_nx;
                     o_tie   <= w_sh_tie_nx;
                     o_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               o_ro_en <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_word.sv
// Scoreboard bench for puf_word with behavioural RO banks of programmable period.
module tb_puf_word;

   localparam int LAT = 16 + 8 * (256 + 2);

   typedef struct {
      logic [7:0] resp;
      logic [7:0] tie;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start, i_start2;
   logic [7:0]  i_chall;
   logic [15:0] raw_a, raw_b;
   logic [15:0] ro_a1, ro_b1, ro_a2, ro_b2;
   logic        o_ro_en1, o_busy1, o_done1, o_ro_en2, o_busy2, o_done2;
   logic [7:0]  o_resp1, o_tie1, o_resp2, o_tie2;

   exp_t q1[$];
   exp_t q2[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   per_a[16];
   int   per_b[16];
   int   k;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign ro_a1 = raw_a & {16{o_ro_en1}};
   assign ro_b1 = raw_b & {16{o_ro_en1}};
   assign ro_a2 = raw_a & {16{o_ro_en2}};
   assign ro_b2 = raw_b & {16{o_ro_en2}};

   puf_word dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_chall(i_chall),
      .i_ro_a(ro_a1), .i_ro_b(ro_b1), .o_ro_en(o_ro_en1), .o_busy(o_busy1),
      .o_done(o_done1), .o_resp(o_resp1), .o_tie(o_tie1)
   );

   puf_word #(.CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_start(i_start2), .i_chall(i_chall),
      .i_ro_a(ro_a2), .i_ro_b(ro_b2), .o_ro_en(o_ro_en2), .o_busy(o_busy2),
      .o_done(o_done2), .o_resp(o_resp2), .o_tie(o_tie2)
   );

   // Oscillators stop and rephase while disabled; ticks fall between clock edges.
   initial begin : ro_gen
      int tick;
      tick  = 0;
      raw_a = '0;
      raw_b = '0;
      #5;
      forever begin
         if (!(o_ro_en1 | o_ro_en2)) begin
            tick  = 0;
            raw_a = '0;
            raw_b = '0;
         end else begin
            tick++;
            for (int i = 0; i < 16; i++) begin
               raw_a[i] = ((tick / per_a[i]) % 2) == 1;
               raw_b[i] = ((tick / per_b[i]) % 2) == 1;
            end
         end
         #10;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst_n && o_done1) begin
         if (q1.size() == 0) begin
            check("done1_unexpected", 64'(o_done1), 64'd0);
         end else begin
            e = q1.pop_front();
            check("resp1", 64'(o_resp1), 64'(e.resp));
            check("tie1", 64'(o_tie1), 64'(e.tie));
            check("done1_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (rst_n && o_done2) begin
         if (q2.size() == 0) begin
            check("done2_unexpected", 64'(o_done2), 64'd0);
         end else begin
            e = q2.pop_front();
            check("resp2", 64'(o_resp2), 64'(e.resp));
            check("tie2", 64'(o_tie2), 64'(e.tie));
            check("done2_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic set_periods(input int pa, input int pb);
      for (int i = 0; i < 16; i++) begin
         per_a[i] = pa;
         per_b[i] = pb;
      end
   endtask

   task automatic start_req(input logic [7:0] ch, input logic [7:0] er, input logic [7:0] et,
                            input bit d2, output int kk);
      exp_t e;
      @(negedge clk);
      i_chall  = ch;
      i_start  = 1'b1;
      i_start2 = d2;
      kk       = cyc + 1;
      e.resp   = er;
      e.tie    = et;
      e.cyc    = kk + LAT;
      q1.push_back(e);
      if (d2) begin
         e.resp = 8'h00;
         e.tie  = 8'hFF;
         q2.push_back(e);
      end
      @(negedge clk);
      i_start  = 1'b0;
      i_start2 = 1'b0;
      check("busy_after_start", 64'(o_busy1), 64'd1);
      check("ro_en_after_start", 64'(o_ro_en1), 64'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((q1.size() != 0 || q2.size() != 0) && n < LAT + 200) begin
         @(negedge clk);
         n++;
      end
      if (q1.size() != 0 || q2.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: no done after %0d cycles", n);
         q1.delete();
         q2.delete();
      end
      repeat (2) @(negedge clk);
      check("busy_after_done", 64'(o_busy1), 64'd0);
      check("ro_en_after_done", 64'(o_ro_en1), 64'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      i_start  = 1'b0;
      i_start2 = 1'b0;
      i_chall  = '0;
      set_periods(4, 6);
      repeat (3) @(negedge clk);
      check("rst_resp", 64'(o_resp1), 64'd0);
      check("rst_tie", 64'(o_tie1), 64'd0);
      check("rst_busy", 64'(o_busy1), 64'd0);
      check("rst_done", 64'(o_done1), 64'd0);
      check("rst_ro_en", 64'(o_ro_en1), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // A faster than B everywhere
      start_req(8'h00, 8'hFF, 8'h00, 1'b0, k);
      wait_done();

      // One slow A oscillator clears bit 3
      per_a[3] = 8;
      start_req(8'h00, 8'hF7, 8'h00, 1'b0, k);
      wait_done();

      // Identical oscillators tie on every bit
      set_periods(5, 5);
      start_req(8'h00, 8'h00, 8'hFF, 1'b0, k);
      wait_done();

      // Fast ROs: 12-bit counters resolve, 4-bit counters saturate and tie
      set_periods(2, 3);
      start_req(8'h00, 8'hFF, 8'h00, 1'b1, k);
      wait_done();

      // Select wrap plus an ignored start during COUNT of bit 1
      set_periods(4, 6);
      per_a[15] = 8;
      per_b[1]  = 3;
      start_req(8'hFE, 8'hF9, 8'h00, 1'b0, k);
      while (cyc < k + 16 + 258 + 100) @(negedge clk);
      i_chall = 8'h00;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("busy_during_ignored_start", 64'(o_busy1), 64'd1);
      wait_done();

      // Reset during COUNT of bit 3, then a clean rerun
      start_req(8'hFE, 8'hF9, 8'h00, 1'b0, k);
      while (cyc < k + 16 + 3 * 258 + 1 + 100) @(negedge clk);
      rst_n = 1'b0;
      q1.delete();
      #1;
      check("midrst_resp", 64'(o_resp1), 64'd0);
      check("midrst_tie", 64'(o_tie1), 64'd0);
      check("midrst_busy", 64'(o_busy1), 64'd0);
      check("midrst_done", 64'(o_done1), 64'd0);
      check("midrst_ro_en", 64'(o_ro_en1), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      start_req(8'hFE, 8'hF9, 8'h00, 1'b0, k);
      wait_done();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
